// File: rtl/grid_pixel_locator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// GridPixelLocator (module grid_pixel_locator)
//
// Purpose:
//   Maps a raster pixel stream onto a grid of square cells. For every accepted
//   pixel it works out the cell (col,row) and the offset inside that cell
//   (x_off,y_off), reads the cell's alive bit from an external cell memory,
//   and presents the offsets plus the cell colour three cycles later for the
//   downstream circle-shaping stage.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   pixel_en     in   an active pixel is present this cycle
//   line_start   in   current pixel starts a line (qualified by pixel_en)
//   frame_start  in   current pixel starts a frame (qualified by pixel_en)
//   cell_rd      out  cell memory read strobe
//   cell_addr    out  cell memory address {row[4:0], col[4:0]}
//   cell_data    in   addressed cell is alive, valid the cycle after cell_rd
//   x_position   out  horizontal offset of the pixel inside its cell
//   y_position   out  vertical offset of the pixel inside its cell
//   color_in     out  cell colour
//   in_grid      out  pixel lies inside the GRID_COLS x GRID_ROWS area
//   out_valid    out  the four outputs above are valid this cycle
//
// Build option:
//   GRID_PIXEL_LOCATOR_GRID_LINES_EN - when defined, in-grid pixels on the
//   first column or first line of a cell are drawn in COLOR_BLANK so the
//   grid shows cell borders.
// ---------------------------------------------------------------------------
module grid_pixel_locator #(
  parameter int          BLOCK_SIZE  = 20,
  parameter int          GRID_COLS   = 32,
  parameter int          GRID_ROWS   = 24,
  parameter logic [7:0]  COLOR_ALIVE = 8'hFF,
  parameter logic [7:0]  COLOR_DEAD  = 8'h00,
  parameter logic [7:0]  COLOR_BLANK = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_en,
  input  logic       line_start,
  input  logic       frame_start,
  output logic       cell_rd,
  output logic [9:0] cell_addr,
  input  logic       cell_data,
  output logic [4:0] x_position,
  output logic [4:0] y_position,
  output logic [7:0] color_in,
  output logic       in_grid,
  output logic       out_valid
);

  localparam logic [4:0] LAST_OFF = 5'(BLOCK_SIZE - 1);
  localparam logic [5:0] COL_MAX  = 6'(GRID_COLS);
  localparam logic [5:0] ROW_MAX  = 6'(GRID_ROWS);

  // r_xOff/r_col hold the position the NEXT ordinary pixel will take, while
  // r_yOff/r_row hold the position of the line currently being drawn. With
  // everything cleared, the first pixel after reset lands on (0,0) even if
  // it carries no frame_start.
  logic [4:0] r_xOff;
  logic [5:0] r_col;
  logic [4:0] r_yOff;
  logic [5:0] r_row;

  logic [4:0] w_curXOff;
  logic [5:0] w_curCol;
  logic [4:0] w_curYOff;
  logic [5:0] w_curRow;
  logic       w_curInGrid;
  logic [4:0] w_nextXOff;
  logic [5:0] w_nextCol;

  logic       r_s1Valid;
  logic [4:0] r_s1XOff;
  logic [4:0] r_s1YOff;
  logic       r_s1InGrid;

  logic       r_s2Valid;
  logic [4:0] r_s2XOff;
  logic [4:0] r_s2YOff;
  logic       r_s2InGrid;

  logic [7:0] w_color;

  // Position of the pixel presented this cycle. frame_start wins over
  // line_start; a line start advances the vertical offset and bumps the row
  // on wrap, with the row pinned once it reaches ROW_MAX (off-grid).
  always_comb begin
    w_curXOff = r_xOff;
    w_curCol  = r_col;
    w_curYOff = r_yOff;
    w_curRow  = r_row;
    if (frame_start) begin
      w_curXOff = 5'd0;
      w_curCol  = 6'd0;
      w_curYOff = 5'd0;
      w_curRow  = 6'd0;
    end else if (line_start) begin
      w_curXOff = 5'd0;
      w_curCol  = 6'd0;
      if (r_yOff == LAST_OFF) begin
        w_curYOff = 5'd0;
        if (r_row != ROW_MAX) begin
          w_curRow = r_row + 6'd1;
        end
      end else begin
        w_curYOff = r_yOff + 5'd1;
      end
    end
  end

  // Horizontal step for the following pixel: the offset wraps at the cell
  // edge and the column counts up, stopping at COL_MAX so a long line stays
  // off-grid instead of wrapping back into the grid.
  always_comb begin
    w_nextXOff = w_curXOff + 5'd1;
    w_nextCol  = w_curCol;
    if (w_curXOff == LAST_OFF) begin
      w_nextXOff = 5'd0;
      if (w_curCol != COL_MAX) begin
        w_nextCol = w_curCol + 6'd1;
      end
    end
  end

  assign w_curInGrid = (w_curCol != COL_MAX) && (w_curRow != ROW_MAX);

  // Counter state only moves on accepted pixels; idle cycles freeze it so
  // blanking gaps inside a line do not disturb the mapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xOff <= 5'd0;
      r_col  <= 6'd0;
      r_yOff <= 5'd0;
      r_row  <= 6'd0;
    end else if (pixel_en) begin
      r_xOff <= w_nextXOff;
      r_col  <= w_nextCol;
      r_yOff <= w_curYOff;
      r_row  <= w_curRow;
    end
  end

  // Stage 1: issue the cell memory read for in-grid pixels and carry the
  // offsets along. The address is left alone for off-grid pixels since the
  // strobe is low anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1Valid  <= 1'b0;
      r_s1XOff   <= 5'd0;
      r_s1YOff   <= 5'd0;
      r_s1InGrid <= 1'b0;
      cell_rd    <= 1'b0;
      cell_addr  <= 10'd0;
    end else begin
      r_s1Valid  <= pixel_en;
      r_s1XOff   <= w_curXOff;
      r_s1YOff   <= w_curYOff;
      r_s1InGrid <= w_curInGrid;
      cell_rd    <= pixel_en & w_curInGrid;
      if (pixel_en && w_curInGrid) begin
        cell_addr <= {w_curRow[4:0], w_curCol[4:0]};
      end
    end
  end

  // Stage 2: wait out the memory read latency; cell_data for this pixel
  // arrives during this stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2Valid  <= 1'b0;
      r_s2XOff   <= 5'd0;
      r_s2YOff   <= 5'd0;
      r_s2InGrid <= 1'b0;
    end else begin
      r_s2Valid  <= r_s1Valid;
      r_s2XOff   <= r_s1XOff;
      r_s2YOff   <= r_s1YOff;
      r_s2InGrid <= r_s1InGrid;
    end
  end

  // Colour choice: off-grid pixels are blank, otherwise the alive bit picks
  // between the live and dead colours. The optional border overlay blanks
  // the first column and first line of every in-grid cell.
  always_comb begin
    w_color = COLOR_BLANK;
    if (r_s2InGrid) begin
      w_color = cell_data ? COLOR_ALIVE : COLOR_DEAD;
    end
`ifdef GRID_PIXEL_LOCATOR_GRID_LINES_EN
    if (r_s2InGrid && ((r_s2XOff == 5'd0) || (r_s2YOff == 5'd0))) begin
      w_color = COLOR_BLANK;
    end
`endif
  end

  // Output stage: registered so the downstream stage sees clean values
  // exactly three cycles after the pixel was accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      x_position <= 5'd0;
      y_position <= 5'd0;
      color_in   <= 8'd0;
      in_grid    <= 1'b0;
    end else begin
      out_valid  <= r_s2Valid;
      x_position <= r_s2XOff;
      y_position <= r_s2YOff;
      color_in   <= w_color;
      in_grid    <= r_s2InGrid;
    end
  end

endmodule

// File: tb/tb_grid_pixel_locator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// TbGridPixelLocator (module tb_grid_pixel_locator)
//
// Purpose:
//   Drives directed pixel streams into grid_pixel_locator, emulates the cell
//   memory, and compares every cycle against a raster-coordinate model that
//   derives cell and offset by division. A set of hand-computed pinned
//   values anchors the model at the interesting points.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_grid_pixel_locator;

  localparam int         BS   = 20;
  localparam int         GC   = 32;
  localparam int         GR   = 24;
  localparam logic [7:0] CA   = 8'hFF;
  localparam logic [7:0] CD   = 8'h5A;
  localparam logic [7:0] CB   = 8'hA5;
  localparam int         NCYC = 4096;

  localparam int K_RD    = 0;
  localparam int K_ADDR  = 1;
  localparam int K_VALID = 2;
  localparam int K_X     = 3;
  localparam int K_Y     = 4;
  localparam int K_COLOR = 5;
  localparam int K_IN    = 6;

  logic       clk;
  logic       reset;
  logic       pixel_en;
  logic       line_start;
  logic       frame_start;
  logic       cell_rd;
  logic [9:0] cell_addr;
  logic       cell_data;
  logic [4:0] x_position;
  logic [4:0] y_position;
  logic [7:0] color_in;
  logic       in_grid;
  logic       out_valid;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  bit         mem [1024];
  bit         expRd    [NCYC];
  logic [9:0] expAddr  [NCYC];
  bit         expValid [NCYC];
  logic [4:0] expX     [NCYC];
  logic [4:0] expY     [NCYC];
  bit         expIn    [NCYC];
  logic [7:0] expColor [NCYC];

  int mPx   = 0;
  int mLine = 0;

  logic       lastRd;
  logic [9:0] lastAddr;

  typedef struct {
    int    c;
    int    kind;
    int    val;
    string name;
  } pin_t;
  pin_t pins [$];

  grid_pixel_locator #(
    .BLOCK_SIZE (BS),
    .GRID_COLS  (GC),
    .GRID_ROWS  (GR),
    .COLOR_ALIVE(CA),
    .COLOR_DEAD (CD),
    .COLOR_BLANK(CB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_en   (pixel_en),
    .line_start (line_start),
    .frame_start(frame_start),
    .cell_rd    (cell_rd),
    .cell_addr  (cell_addr),
    .cell_data  (cell_data),
    .x_position (x_position),
    .y_position (y_position),
    .color_in   (color_in),
    .in_grid    (in_grid),
    .out_valid  (out_valid)
  );

  // Free-running clock and a cycle number that identifies each clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Cell memory emulation: capture the read request mid-cycle and answer
  // with the stored alive bit during the following cycle.
  always @(negedge clk) begin
    lastRd   = cell_rd;
    lastAddr = cell_addr;
  end

  always @(posedge clk) begin
    #1;
    cell_data = (lastRd === 1'b1) ? mem[lastAddr] : 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, actual, expected);
    end
  endtask

  task automatic addPin(input int c, input int kind, input int val, input string name);
    pin_t p;
    p.c = c;
    p.kind = kind;
    p.val = val;
    p.name = name;
    pins.push_back(p);
  endtask

  function automatic logic [31:0] probe(input int kind);
    case (kind)
      K_RD:    return {31'd0, cell_rd};
      K_ADDR:  return {22'd0, cell_addr};
      K_VALID: return {31'd0, out_valid};
      K_X:     return {27'd0, x_position};
      K_Y:     return {27'd0, y_position};
      K_COLOR: return {24'd0, color_in};
      default: return {31'd0, in_grid};
    endcase
  endfunction

  // Model: raster x counts pixels since the line start, raster y counts
  // lines since the frame start; cell and offset fall out of divide and
  // modulo, with cell indices clamped at the grid size.
  task automatic modelPixel(input int t, input logic ls, input logic fs);
    int px, py, col, row, addr;
    bit ig;
    logic [7:0] colr;
    if (fs) begin
      px = 0;
      py = 0;
    end else if (ls) begin
      px = 0;
      py = mLine + 1;
    end else begin
      px = mPx;
      py = mLine;
    end
    mPx   = px + 1;
    mLine = py;
    col  = (px / BS > GC) ? GC : px / BS;
    row  = (py / BS > GR) ? GR : py / BS;
    ig   = (col < GC) && (row < GR);
    addr = row * 32 + col;
    colr = CB;
    if (ig) colr = mem[addr] ? CA : CD;
`ifdef GRID_PIXEL_LOCATOR_GRID_LINES_EN
    if (ig && ((px % BS == 0) || (py % BS == 0))) colr = CB;
`endif
    if (t + 3 < NCYC) begin
      expRd[t+1]    = ig;
      expAddr[t+1]  = 10'(addr);
      expValid[t+3] = 1'b1;
      expX[t+3]     = 5'(px % BS);
      expY[t+3]     = 5'(py % BS);
      expIn[t+3]    = ig;
      expColor[t+3] = colr;
    end
  endtask

  // A reset drops everything still in the pipe and restarts the raster.
  task automatic modelReset(input int t);
    for (int c = t + 1; c <= t + 4; c++) begin
      if (c < NCYC) begin
        expRd[c]    = 1'b0;
        expValid[c] = 1'b0;
      end
    end
    mPx   = 0;
    mLine = 0;
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic ls,
                               input logic fs);
    @(posedge clk);
    #1;
    reset       = rst;
    pixel_en    = en;
    line_start  = ls;
    frame_start = fs;
    if (rst) modelReset(cyc);
    else if (en) modelPixel(cyc, ls, fs);
  endtask

  // Per-cycle comparison against the model, plus any pinned values due now.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      if (expRd[cyc]) begin
        checkOutput("cell_rd", {31'd0, cell_rd}, 32'd1);
        checkOutput("cell_addr", {22'd0, cell_addr}, {22'd0, expAddr[cyc]});
      end else begin
        checkOutput("cell_rd", {31'd0, cell_rd}, 32'd0);
      end
      if (expValid[cyc]) begin
        checkOutput("out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("x_position", {27'd0, x_position}, {27'd0, expX[cyc]});
        checkOutput("y_position", {27'd0, y_position}, {27'd0, expY[cyc]});
        checkOutput("in_grid", {31'd0, in_grid}, {31'd0, expIn[cyc]});
        checkOutput("color_in", {24'd0, color_in}, {24'd0, expColor[cyc]});
      end else begin
        checkOutput("out_valid", {31'd0, out_valid}, 32'd0);
      end
      for (int i = pins.size() - 1; i >= 0; i--) begin
        if (pins[i].c == cyc) begin
          checkOutput(pins[i].name, probe(pins[i].kind), 32'(pins[i].val));
          pins.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d fails=%0d",
             tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    reset       = 1'b1;
    pixel_en    = 1'b0;
    line_start  = 1'b0;
    frame_start = 1'b0;
    cell_data   = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = (i % 3 == 0);

    addPin(2, K_RD, 0, "reset cell_rd");
    addPin(2, K_ADDR, 0, "reset cell_addr");
    addPin(2, K_VALID, 0, "reset out_valid");
    addPin(2, K_X, 0, "reset x_position");
    addPin(2, K_Y, 0, "reset y_position");
    addPin(2, K_COLOR, 0, "reset color_in");
    addPin(2, K_IN, 0, "reset in_grid");

    repeat (3) applyStimulus(1, 0, 0, 0);
    while (cyc < 9) applyStimulus(0, 0, 0, 0);

    // Frame start at cycle 10, then the rest of a 680-pixel line.
    applyStimulus(0, 1, 0, 1);
    addPin(11, K_RD, 1, "fs cell_rd");
    addPin(11, K_ADDR, 0, "fs cell_addr");
    addPin(13, K_VALID, 1, "fs out_valid");
    addPin(13, K_X, 0, "fs x_position");
    addPin(13, K_Y, 0, "fs y_position");
    addPin(32, K_X, 19, "px19 x_position");
    addPin(31, K_ADDR, 1, "px20 cell_addr");
    addPin(33, K_X, 0, "px20 x_position");
    addPin(33, K_IN, 1, "px20 in_grid");
    addPin(51, K_ADDR, 2, "px40 cell_addr");
    addPin(53, K_X, 0, "px40 x_position");
    addPin(650, K_RD, 1, "px639 cell_rd");
    addPin(650, K_ADDR, 31, "px639 cell_addr");
    addPin(651, K_RD, 0, "px640 cell_rd");
    addPin(653, K_VALID, 1, "px640 out_valid");
    addPin(653, K_IN, 0, "px640 in_grid");
    addPin(653, K_COLOR, 32'(CB), "px640 color_in");
    addPin(653, K_X, 0, "px640 x_position");
    addPin(690, K_RD, 0, "px679 cell_rd");
    addPin(692, K_IN, 0, "px679 in_grid");
    addPin(692, K_X, 19, "px679 x_position");
    for (int k = 1; k < 680; k++) applyStimulus(0, 1, 0, 0);
    repeat (5) applyStimulus(0, 0, 0, 0);

    // New frame with twenty one-pixel lines: the twentieth enters row 1.
    applyStimulus(0, 1, 0, 1);
    for (int j = 1; j <= 20; j++) begin
      applyStimulus(0, 1, 1, 0);
      if (j == 19) begin
        addPin(cyc + 1, K_ADDR, 0, "line19 cell_addr");
        addPin(cyc + 3, K_Y, 19, "line19 y_position");
      end
      if (j == 20) begin
        addPin(cyc + 1, K_RD, 1, "line20 cell_rd");
        addPin(cyc + 1, K_ADDR, 32, "line20 cell_addr");
        addPin(cyc + 3, K_Y, 0, "line20 y_position");
      end
    end
    repeat (2) applyStimulus(0, 1, 0, 0);
    addPin(cyc + 3, K_X, 2, "line20 px2 x_position");
    repeat (3) applyStimulus(0, 0, 0, 0);
    repeat (2) applyStimulus(0, 1, 0, 0);
    addPin(cyc + 3, K_X, 4, "gap x_position");

    // Keep adding lines until the row count runs off the bottom of the grid.
    for (int j = 21; j <= 490; j++) begin
      applyStimulus(0, 1, 1, 0);
      if (j == 479) addPin(cyc + 1, K_ADDR, 736, "line479 cell_addr");
      if (j == 480) begin
        addPin(cyc + 1, K_RD, 0, "line480 cell_rd");
        addPin(cyc + 3, K_IN, 0, "line480 in_grid");
        addPin(cyc + 3, K_COLOR, 32'(CB), "line480 color_in");
        addPin(cyc + 3, K_Y, 0, "line480 y_position");
      end
    end
    repeat (3) applyStimulus(0, 1, 0, 0);

    // frame_start together with line_start must land on cell (0,0).
    applyStimulus(0, 1, 1, 1);
    addPin(cyc + 1, K_RD, 1, "fs+ls cell_rd");
    addPin(cyc + 1, K_ADDR, 0, "fs+ls cell_addr");
    addPin(cyc + 3, K_X, 0, "fs+ls x_position");
    addPin(cyc + 3, K_Y, 0, "fs+ls y_position");
    addPin(cyc + 3, K_IN, 1, "fs+ls in_grid");
`ifndef GRID_PIXEL_LOCATOR_GRID_LINES_EN
    addPin(cyc + 3, K_COLOR, 255, "fs+ls color_in");
`endif
    repeat (4) applyStimulus(0, 1, 0, 0);

    // Reset with three pixels in flight, then an unflagged pixel.
    repeat (2) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    r = cyc;
    addPin(r + 1, K_VALID, 0, "rst out_valid");
    addPin(r + 1, K_RD, 0, "rst cell_rd");
    addPin(r + 1, K_ADDR, 0, "rst cell_addr");
    addPin(r + 1, K_X, 0, "rst x_position");
    addPin(r + 1, K_COLOR, 0, "rst color_in");
    addPin(r + 2, K_VALID, 0, "rst+2 out_valid");
    addPin(r + 3, K_VALID, 0, "rst+3 out_valid");
    applyStimulus(0, 1, 0, 0);
    addPin(r + 2, K_RD, 1, "post-rst cell_rd");
    addPin(r + 2, K_ADDR, 0, "post-rst cell_addr");
    addPin(r + 4, K_VALID, 1, "post-rst out_valid");
    addPin(r + 4, K_X, 0, "post-rst x_position");
    addPin(r + 4, K_Y, 0, "post-rst y_position");
    repeat (3) applyStimulus(0, 1, 0, 0);
    repeat (8) applyStimulus(0, 0, 0, 0);

    @(posedge clk);
    #2;
    foreach (pins[i]) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: pinned check at cycle %0d never reached, expected 0x%0h",
               pins[i].name, pins[i].c, pins[i].val);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_pixel_locator.md
GRID_PIXEL_LOCATOR -- requirements
Module: grid_pixel_locator

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 20, meaning the pixel edge length of one square cell (3..31).
REQ-002 SHALL have parameter GRID_COLS, default 32, meaning the number of cell columns (at most 32).
REQ-003 SHALL have parameter GRID_ROWS, default 24, meaning the number of cell rows (at most 32).
REQ-004 SHALL have parameters COLOR_ALIVE (default 8'hFF), COLOR_DEAD (default 8'h00) and COLOR_BLANK (default 8'h00), meaning the 8-bit colours for a live cell, a dead cell and off-grid pixels.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pixel_en, input, 1 bit: an active pixel is present this cycle.
REQ-008 SHALL have port line_start, input, 1 bit: the current pixel is the first of a line; qualified by pixel_en.
REQ-009 SHALL have port frame_start, input, 1 bit: the current pixel is the first of a frame; qualified by pixel_en.
REQ-010 SHALL have port cell_rd, output, 1 bit: cell memory read strobe.
REQ-011 SHALL have port cell_addr, output, 10 bits: cell memory address {row[4:0], col[4:0]}.
REQ-012 SHALL have port cell_data, input, 1 bit: the addressed cell is alive; valid the cycle after cell_rd.
REQ-013 SHALL have port x_position, output, 5 bits: horizontal offset of the pixel inside its cell.
REQ-014 SHALL have port y_position, output, 5 bits: vertical offset of the pixel inside its cell.
REQ-015 SHALL have port color_in, output, 8 bits: the cell colour, fed to the downstream circle-shaping stage.
REQ-016 SHALL have port in_grid, output, 1 bit: the pixel lies inside the GRID_COLS x GRID_ROWS area.
REQ-017 SHALL have port out_valid, output, 1 bit: x_position, y_position, color_in and in_grid are valid this cycle.

Function
REQ-018 SHALL keep counters x_off (0..BLOCK_SIZE-1), col (0..GRID_COLS), y_off (0..BLOCK_SIZE-1) and row (0..GRID_ROWS), using no divider or multiplier.
REQ-019 SHALL, when pixel_en is low, hold all counters and ignore line_start and frame_start.
REQ-020 SHALL, on a pixel with frame_start, map that pixel to x_off=col=y_off=row=0; frame_start takes priority over a simultaneous line_start.
REQ-021 SHALL, on a pixel with line_start and no frame_start, map that pixel to x_off=col=0 with y_off advanced by one; at y_off=BLOCK_SIZE-1 y_off wraps to 0 and row increments.
REQ-022 SHALL, on any other pixel, advance x_off by one; at x_off=BLOCK_SIZE-1 x_off wraps to 0 and col increments.
REQ-023 SHALL saturate col at GRID_COLS and row at GRID_ROWS; a saturated counter marks the pixel off-grid.
REQ-024 SHALL, for a pixel accepted in cycle T, drive cell_rd=1 and cell_addr during T+1 if the pixel is in-grid, and drive cell_rd=0 otherwise.
REQ-025 SHALL sample cell_data in T+2 and present registered outputs in T+3 with out_valid=1, so latency is exactly 3 cycles.
REQ-026 SHALL set color_in to COLOR_ALIVE or COLOR_DEAD from cell_data when in_grid=1, and to COLOR_BLANK when in_grid=0.
REQ-027 SHALL carry x_position and y_position through the pipeline unchanged from x_off and y_off, including for off-grid pixels.
REQ-028 SHALL sustain one pixel per cycle with no back-pressure; a pixel_en gap yields an out_valid gap of equal length.

Reset
REQ-029 SHALL clear all counters, the pipeline valid bits, cell_rd, cell_addr, x_position, y_position, color_in, in_grid and out_valid to 0 on reset.
REQ-030 SHALL discard pixels in flight when reset asserts mid-frame, and after reset treat the next pixel as x_off=col=y_off=row=0.

Configuration
REQ-031 SHALL, when GRID_PIXEL_LOCATOR_GRID_LINES_EN is defined, force color_in to COLOR_BLANK for in-grid pixels with x_off=0 or y_off=0, drawing cell borders.
REQ-032 SHALL, when GRID_PIXEL_LOCATOR_GRID_LINES_EN is undefined, omit the border logic entirely; colour follows REQ-026.

Verification
REQ-033 SHALL cover: frame_start pixel at cycle 10 -> cell_rd=1, cell_addr=0 at cycle 11; out_valid=1, x/y_position=0 at cycle 13.
REQ-034 SHALL cover: 41 consecutive pixels after frame_start -> pixel 20 gives col=1 and x_position=0; pixel 40 gives col=2 and x_position=0.
REQ-035 SHALL cover: a line of 680 pixels -> pixels 640..679 give in_grid=0, color_in=COLOR_BLANK, cell_rd=0.
REQ-036 SHALL cover: 20 line_start pulses after frame_start -> row=1, y_position=0, cell_addr upper bits=1.
REQ-037 SHALL cover: frame_start and line_start on the same pixel -> mapped as (0,0); cell_data=1 returns color_in=8'hFF.
REQ-038 SHALL cover: reset asserted for 1 cycle with 3 pixels in flight -> no out_valid for those 3 pixels; the next pixel is mapped as (0,0).
